// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: one FSM shares a single valid/ready memory port
// between instruction fetch and data access; illegal, ecall and ebreak halt the core.
module riscv_multicycle_core #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          RV32E    = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              halted_o,
    output logic [31:0]       pc_out_o,
    output logic [31:0]       instret_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] imm_q, imm_d, alu_q, alu_d, instret_q, instret_d;
    logic [31:0] rf_q [32];

    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    logic [6:0]  opcode_s, funct7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic        is_r_s, is_i_s, is_lw_s, is_sw_s, is_br_s, is_jal_s;
    logic        e_bad_s, legal_s, taken_s;
    logic [31:0] imm_sel_s, opb_s, alu_res_s, addr_sum_s;

    assign opcode_s = ir_q[6:0];
    assign rd_s     = ir_q[11:7];
    assign funct3_s = ir_q[14:12];
    assign rs1_s    = ir_q[19:15];
    assign rs2_s    = ir_q[24:20];
    assign funct7_s = ir_q[31:25];

    assign is_r_s   = (opcode_s == 7'b0110011) &&
                      (((funct7_s == 7'b0000000) && ((funct3_s == 3'b000) || (funct3_s == 3'b010) ||
                                                     (funct3_s == 3'b110) || (funct3_s == 3'b111))) ||
                       ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)));
    assign is_i_s   = (opcode_s == 7'b0010011) &&
                      ((funct3_s == 3'b000) || (funct3_s == 3'b010) ||
                       (funct3_s == 3'b110) || (funct3_s == 3'b111));
    assign is_lw_s  = (opcode_s == 7'b0000011) && (funct3_s == 3'b010);
    assign is_sw_s  = (opcode_s == 7'b0100011) && (funct3_s == 3'b010);
    assign is_br_s  = (opcode_s == 7'b1100011) &&
                      ((funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                       (funct3_s == 3'b100) || (funct3_s == 3'b101));
    assign is_jal_s = (opcode_s == 7'b1101111);

    // Only register fields actually used by the instruction are range-checked in RV32E mode
    assign e_bad_s  = RV32E &&
                      (((is_r_s || is_i_s || is_lw_s || is_sw_s || is_br_s) && rs1_s[4]) ||
                       ((is_r_s || is_sw_s || is_br_s) && rs2_s[4]) ||
                       ((is_r_s || is_i_s || is_lw_s || is_jal_s) && rd_s[4]));
    assign legal_s  = (is_r_s || is_i_s || is_lw_s || is_sw_s || is_br_s || is_jal_s) && !e_bad_s;

    // Immediate selection by instruction format
    always_comb begin
        if (is_sw_s) begin
            imm_sel_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        end else if (is_br_s) begin
            imm_sel_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        end else if (is_jal_s) begin
            imm_sel_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        end else begin
            imm_sel_s = {{20{ir_q[31]}}, ir_q[31:20]};
        end
    end

    // ALU result, load/store address and branch condition
    always_comb begin
        opb_s      = is_r_s ? b_q : imm_q;
        addr_sum_s = a_q + imm_q;
        case (funct3_s)
            3'b000:  alu_res_s = (is_r_s && funct7_s[5]) ? (a_q - opb_s) : (a_q + opb_s);
            3'b010:  alu_res_s = {31'd0, ($signed(a_q) < $signed(opb_s))};
            3'b110:  alu_res_s = a_q | opb_s;
            3'b111:  alu_res_s = a_q & opb_s;
            default: alu_res_s = a_q + opb_s;
        endcase
        case (funct3_s)
            3'b000:  taken_s = (a_q == b_q);
            3'b001:  taken_s = (a_q != b_q);
            3'b100:  taken_s = ($signed(a_q) < $signed(b_q));
            3'b101:  taken_s = ($signed(a_q) >= $signed(b_q));
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        alu_d      = alu_q;
        instret_d  = instret_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = rd_s;
        rf_wdata_s = alu_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d   = rf_q[rs1_s];
                b_d   = rf_q[rs2_s];
                imm_d = imm_sel_s;
                if (legal_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_br_s) begin
                    pc_d      = taken_s ? (pc_q + imm_q) : (pc_q + 32'd4);
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end else if (is_jal_s) begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = pc_q + 32'd4;
                    pc_d       = pc_q + imm_q;
                    instret_d  = instret_q + 32'd1;
                    state_d    = S_FETCH;
                end else if (is_lw_s || is_sw_s) begin
                    alu_d = addr_sum_s;
                    if (addr_sum_s[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    alu_d   = alu_res_s;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_ready_i) begin
                    state_d = S_MEM;
                end else if (is_lw_s) begin
                    alu_d   = mem_rdata_i;
                    state_d = S_WB;
                end else begin
                    pc_d      = pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                rf_we_s   = 1'b1;
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            imm_q     <= 32'd0;
            alu_q     <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            instret_q <= instret_d;
        end
    end

    // Register file; x0 and (in RV32E) the upper half are never written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we_s && (rf_waddr_s != 5'd0) && (!RV32E || !rf_waddr_s[4])) begin
            rf_q[rf_waddr_s] <= rf_wdata_s;
        end
    end

    // Moore memory-port decode; idle bus fields are forced to zero
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = 32'd0;
        if ((state_q == S_FETCH) && (pc_q[1:0] == 2'b00)) begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_q[ADDR_W-1:0];
        end else if (state_q == S_MEM) begin
            mem_req_o   = 1'b1;
            mem_we_o    = is_sw_s;
            mem_addr_o  = alu_q[ADDR_W-1:0];
            mem_wdata_o = b_q;
        end else begin
            mem_req_o = 1'b0;
        end
    end

    assign halted_o  = (state_q == S_HALT);
    assign pc_out_o  = pc_q;
    assign instret_o = instret_q;
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed self-checking bench for riscv_multicycle_core with a zero/variable-wait
// word memory model and a second RV32E instance.
module tb_riscv_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instret;
    logic        e_req, e_we, e_halted;
    logic [31:0] e_addr, e_wdata, e_rdata, e_pc_out, e_instret;

    logic [31:0] mem   [0:255];
    logic [31:0] e_mem [0:255];
    logic [31:0] log_addr [0:31];
    logic [31:0] last_waddr, last_wdata;
    int          cyc, wr_cnt, log_n, last_wcycle;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign e_rdata   = e_mem[e_addr[9:2]];

    riscv_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0000_0040), .RV32E(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .halted_o(halted), .pc_out_o(pc_out), .instret_o(instret)
    );

    riscv_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .RV32E(1'b1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_o(e_req), .mem_we_o(e_we),
        .mem_addr_o(e_addr), .mem_wdata_o(e_wdata), .mem_rdata_i(e_rdata),
        .mem_ready_i(1'b1), .halted_o(e_halted), .pc_out_o(e_pc_out), .instret_o(e_instret)
    );

    // Bus monitor: handshake log, store record and cycle count since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; wr_cnt <= 0; log_n <= 0; last_wcycle <= 0;
            last_waddr <= 32'd0; last_wdata <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (mem_req && mem_ready) begin
                if (log_n < 32) log_addr[log_n] <= mem_addr;
                log_n <= log_n + 1;
                if (mem_we) begin
                    wr_cnt <= wr_cnt + 1; last_waddr <= mem_addr;
                    last_wdata <= mem_wdata; last_wcycle <= cyc;
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic start();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[16] = EBREAK;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got req=%b we=%b expected 0 0", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
        checks++; if (halted !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL reset_status: got halted=%b instret=%0d expected 0 0", halted, instret); end
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL reset_pc: got %h expected 00000040", pc_out); end
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_cycle: got req=%b expected 0", mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL first_fetch: got req=%b addr=%h expected 1 00000040", mem_req, mem_addr); end
    endtask

    task automatic test_arith();
        clear_mem();
        mem[16] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem[17] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
        mem[18] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        mem[19] = enc_s(12'h100, 5'd3, 5'd0);
        mem[20] = EBREAK;
        mem_ready = 1'b1;
        start();
        for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL arith_halt: got halted=%b expected 1", halted); end
        checks++; if (wr_cnt !== 1 || last_waddr !== 32'h100 || last_wdata !== 32'd2) begin errors++; $display("FAIL arith_store: got n=%0d addr=%h data=%h expected 1 00000100 00000002", wr_cnt, last_waddr, last_wdata); end
        checks++; if (last_wcycle !== 16) begin errors++; $display("FAIL arith_store_cycle: got %0d expected 16", last_wcycle); end
        checks++; if (instret !== 32'd4 || pc_out !== 32'h50) begin errors++; $display("FAIL arith_ebreak: got instret=%0d pc=%h expected 4 00000050", instret, pc_out); end
    endtask

    task automatic test_wait_states();
        clear_mem();
        mem[16]  = enc_i(12'h200, 5'd0, 3'b010, 5'd4, 7'b0000011);
        mem[17]  = enc_s(12'h104, 5'd4, 5'd0);
        mem[18]  = EBREAK;
        mem[128] = 32'hDEAD_BEEF;
        mem_ready = 1'b0;
        start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL fetch_wait: got req=%b addr=%h we=%b pc=%h expected 1 00000040 0 00000040", mem_req, mem_addr, mem_we, pc_out); end
        end
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL load_wait: got req=%b addr=%h we=%b wdata=%h expected 1 00000200 0 0", mem_req, mem_addr, mem_we, mem_wdata); end
        end
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL load_wb_cycle: got instret=%0d expected 0", instret); end
        @(negedge clk);
        checks++; if (instret !== 32'd1 || pc_out !== 32'h44) begin errors++; $display("FAIL load_retire_11: got instret=%0d pc=%h expected 1 00000044", instret, pc_out); end
        for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (last_waddr !== 32'h104 || last_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got addr=%h data=%h expected 00000104 deadbeef", last_waddr, last_wdata); end
    endtask

    task automatic test_branches();
        logic [31:0] exp_addr [0:11];
        exp_addr = '{32'h40, 32'h44, 32'h48, 32'h50, 32'h54, 32'h60,
                     32'h108, 32'h64, 32'h60, 32'h108, 32'h64, 32'h60};
        clear_mem();
        mem[16] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem[17] = enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'b0010011);
        mem[18] = enc_b(13'd8, 5'd2, 5'd1, 3'b100);
        mem[19] = EBREAK;
        mem[20] = enc_b(13'd8, 5'd2, 5'd1, 3'b101);
        mem[21] = enc_j(21'd12, 5'd5);
        mem[22] = EBREAK;
        mem[23] = EBREAK;
        mem[24] = enc_s(12'h108, 5'd5, 5'd0);
        mem[25] = enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000);
        mem_ready = 1'b1;
        start();
        for (int i = 0; i < 200 && log_n < 12; i++) @(negedge clk);
        checks++; if (log_n < 12 || halted !== 1'b0) begin errors++; $display("FAIL branch_progress: got handshakes=%0d halted=%b expected >=12 0", log_n, halted); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (log_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL branch_seq[%0d]: got %h expected %h", i, log_addr[i], exp_addr[i]); end
        end
        checks++; if (last_wdata !== 32'h58) begin errors++; $display("FAIL jal_link: got %h expected 00000058", last_wdata); end
    endtask

    task automatic test_halt_paths();
        clear_mem();
        mem[16] = enc_i(12'h102, 5'd0, 3'b010, 5'd1, 7'b0000011);
        mem_ready = 1'b1;
        start();
        for (int i = 0; i < 50 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (halted !== 1'b1 || log_n !== 1 || instret !== 32'd0) begin errors++; $display("FAIL misaligned_lw: got halted=%b handshakes=%0d instret=%0d expected 1 1 0", halted, log_n, instret); end
        mem_ready = 1'b0; @(negedge clk);
        mem_ready = 1'b1; @(negedge clk);
        mem_ready = 1'b0; @(negedge clk);
        mem_ready = 1'b1; repeat (2) @(negedge clk);
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'd0 || log_n !== 1 || pc_out !== 32'h40) begin errors++; $display("FAIL halt_sticky: got halted=%b req=%b addr=%h handshakes=%0d pc=%h expected 1 0 0 1 00000040", halted, mem_req, mem_addr, log_n, pc_out); end

        clear_mem();
        mem[16] = enc_b(13'd6, 5'd0, 5'd0, 3'b000);
        start();
        for (int i = 0; i < 50 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (halted !== 1'b1 || log_n !== 1 || pc_out !== 32'h46 || instret !== 32'd1) begin errors++; $display("FAIL misaligned_pc: got halted=%b handshakes=%0d pc=%h instret=%0d expected 1 1 00000046 1", halted, log_n, pc_out, instret); end

        clear_mem();
        mem[16] = EBREAK;
        mem_ready = 1'b0;
        start();
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_abort_req: got %b expected 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || halted !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL async_abort: got req=%b halted=%b pc=%h expected 0 0 00000040", mem_req, halted, pc_out); end
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (halted !== 1'b1 || log_n !== 1 || instret !== 32'd0) begin errors++; $display("FAIL reset_recover: got halted=%b handshakes=%0d instret=%0d expected 1 1 0", halted, log_n, instret); end
    endtask

    task automatic test_x0();
        clear_mem();
        mem[16] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
        mem[17] = enc_s(12'd0, 5'd0, 5'd0);
        mem[18] = EBREAK;
        mem_ready = 1'b1;
        start();
        for (int i = 0; i < 50 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (wr_cnt !== 1 || last_waddr !== 32'd0 || last_wdata !== 32'd0 || instret !== 32'd2) begin errors++; $display("FAIL x0_write: got n=%0d addr=%h data=%h instret=%0d expected 1 0 0 2", wr_cnt, last_waddr, last_wdata, instret); end
    endtask

    task automatic test_rv32e();
        start();
        for (int i = 0; i < 50 && e_halted !== 1'b1; i++) @(negedge clk);
        checks++; if (e_halted !== 1'b1 || e_instret !== 32'd1 || e_pc_out !== 32'd4) begin errors++; $display("FAIL rv32e_x16: got halted=%b instret=%0d pc=%h expected 1 1 00000004", e_halted, e_instret, e_pc_out); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) e_mem[i] = 32'd0;
        e_mem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);
        e_mem[1] = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd16);
        e_mem[2] = EBREAK;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_arith();
        test_wait_states();
        test_branches();
        test_halt_paths();
        test_x0();
        test_rv32e();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Parametrised multi-cycle RV32I-subset processor core: one FSM sequences fetch, decode, execute, memory and write-back over a single shared memory port with a valid/ready handshake. It replaces the single-cycle processor top and its separate instruction/data memories. Variable-latency memory, an optional RV32E register file, a retired-instruction counter and a halt state are new behaviour. It sits between the system memory/bus and the testbench or SoC top.

## Interface
- `ADDR_W`, default 32: memory address width; `mem_addr = addr[ADDR_W-1:0]`.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `RV32E`, default 0: 1 gives 16 registers, and any rs1/rs2/rd index ≥16 is illegal.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_req`  out  1: transfer request.
- `mem_we`  out  1: 1 = word store, 0 = word read.
- `mem_addr`  out  ADDR_W: byte address, always word-aligned.
- `mem_wdata`  out  32: store data.
- `mem_rdata`  in  32: read data, valid when `mem_ready` is high.
- `mem_ready`  in  1: transfer completes at the rising edge where `mem_req && mem_ready`.
- `halted`  out  1: core stopped.
- `pc_out`  out  32: current PC.
- `instret`  out  32: retired-instruction count.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt.
  - I-type: addi, andi, ori, slti.
  - Memory: lw, sw.
  - Branches: beq, bne, blt, bge.
  - Jump: jal.
  - ecall/ebreak halt the core.
  - Every other encoding is illegal and halts the core.
- Comparisons in slt, slti, blt and bge are signed 32-bit. All arithmetic wraps mod 2^32.
- Writes to x0 are discarded; x0 always reads 0.
- FSM states:
  - IDLE: entered on reset; goes to FETCH on the next edge.
  - FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=pc`. Holds until ready; on ready, latch IR and go to DECODE. If `pc[1:0]!=0`, go to HALT without asserting `mem_req`.
  - DECODE: latch A=rs1, B=rs2 and the sign-extended immediate (I/S/B/J). Illegal, ecall or ebreak go to HALT. Otherwise go to EXEC.
  - EXEC, R/I-type: ALUOut = A op (B or imm), then WB.
  - EXEC, branch: `pc <= taken ? pc+immB : pc+4`, retire, then FETCH.
  - EXEC, jal: `x[rd] <= pc+4`, `pc <= pc+immJ`, retire, then FETCH.
  - EXEC, lw/sw: ALUOut = A+imm, then MEM. If `ALUOut[1:0]!=0`, go to HALT instead.
  - MEM: `mem_req=1`, `mem_addr=ALUOut`, `mem_we=` store, `mem_wdata=B`. On ready: a load latches `mem_rdata` and goes to WB; a store sets `pc+=4`, retires and goes to FETCH.
  - WB: `x[rd] <=` result, `pc += 4`, retire, then FETCH.
  - HALT: terminal; `halted=1`, `mem_req=0`. Only reset exits it.
- Retire means `instret += 1`, wrapping at 2^32. A halting instruction does not retire.
- Outputs when `mem_req=0`: `mem_we`, `mem_addr` and `mem_wdata` are driven to 0.

## Timing
- Reset values:
  - state IDLE, `pc=RESET_PC`.
  - All registers 0, IR 0.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `halted=0`, `instret=0`.
- Reset applied mid-transfer drops `mem_req` immediately (asynchronously), and the transfer is abandoned.
- `mem_req` is Moore, decoded from the state. While the core waits for ready, `mem_addr`, `mem_we` and `mem_wdata` stay stable.
- `mem_ready` is ignored while `mem_req=0`. Ready may already be high in the first request cycle (zero wait).
- Cycles per instruction at zero wait:
  - ALU op: 4 (F, D, E, WB).
  - Load: 5.
  - Store: 4.
  - Branch or jal: 3.
  - Each wait cycle on a transfer adds 1.
- `instret` and `pc_out` update at the retiring edge.
- `halted` rises at the edge that enters HALT.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `RESET_PC=0x40` -> all outputs at reset values and `pc_out=0x40`. Release `rst` -> 1 IDLE cycle, then `mem_req=1`, `mem_addr=0x40`.
- Arithmetic: run `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2`; `sw x3,0x100(x0)` at zero wait -> one write with addr 0x100, data 2. The store handshake occurs at cycle 16 after IDLE, and `instret=4` afterwards.
- Wait states: hold `mem_ready` low for 3 cycles during a fetch and a load -> `mem_req`, `mem_addr` and state are unchanged throughout. The load completes with `mem_rdata` written to rd, and the total is 5+6 cycles.
- Branches:
  - x1=-1, x2=1, `blt x1,x2,+8` -> next fetch at pc+8.
  - `bge` with the same operands -> next fetch at pc+4.
  - `beq x0,x0,-4` -> loops.
  - `jal x5,+12` -> x5=pc+4, next fetch at pc+12.
- Halt paths:
  - `lw` to address 0x102 -> `halted=1` and no data request.
  - ebreak -> `halted=1` with `instret` not incremented.
  - A later `mem_ready` pulse has no effect.
  - Reset recovers the core.
- x0 and RV32E: `addi x0,x0,7` followed by `sw x0,0(x0)` -> stored data 0. With `RV32E=1`, `add x16,x1,x1` -> halt.
